time_slot_scheduler: RTL and testbench

Slot scheduler that sits downstream of the time-synchronisation block on each control port. It turns the synchronised 64-bit local time and the post-sync slot-start pulse into globally aligned slot boundaries, a slot ID and a guarded TX window for the optical datapath. It also requests periodic re-synchronisation and declares sync loss when a re-sync does not complete.

---
 rtl/time_slot_pkg.sv | 18 +
 rtl/slot_time_decoder.sv | 31 +++
 rtl/time_slot_scheduler.sv | 159 +++++++++++++++
 tb/tb_time_slot_scheduler.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/time_slot_pkg.sv
// Shared widths, FSM encodings and helpers for the slot scheduler.
package time_slot_pkg;

  localparam int unsigned SLOT_ID_W = 8;
  localparam int unsigned CNT_W     = 16;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE       = 2'd0;
  localparam state_t ST_WAIT_ALIGN = 2'd1;
  localparam state_t ST_GUARD      = 2'd2;
  localparam state_t ST_ACTIVE     = 2'd3;

  function automatic logic is_aligned(input state_t s);
    return (s == ST_GUARD) || (s == ST_ACTIVE);
  endfunction

endpackage

// File: rtl/slot_time_decoder.sv
// Decodes slot boundary, in-slot offset and time discontinuity from local time.
module slot_time_decoder #(
  parameter int unsigned P_SLOT_LEN_LOG2 = 10
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [63:0]                i_local_time,
  output logic                       o_boundary,
  output logic [P_SLOT_LEN_LOG2-1:0] o_offset,
  output logic                       o_jump
);

  logic [63:0] prev_q;
  logic        prev_vld_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
    end else begin
      prev_q     <= i_local_time;
      prev_vld_q <= 1'b1;
    end
  end

  assign o_offset   = i_local_time[P_SLOT_LEN_LOG2-1:0];
  assign o_boundary = (o_offset == '0);
  // All-ones to zero is a legal +1 step thanks to modulo-2^64 addition.
  assign o_jump     = prev_vld_q && (i_local_time != prev_q + 64'd1);

endmodule

// File: rtl/time_slot_scheduler.sv
// Aligns slot boundaries to synchronised time, gates the TX window and
// supervises periodic re-synchronisation.
module time_slot_scheduler
  import time_slot_pkg::*;
#(
  parameter int unsigned P_SLOT_LEN_LOG2  = 10,
  parameter int unsigned P_SLOT_NUM_LOG2  = 3,
  parameter int unsigned P_GUARD_LEN      = 64,
  parameter int unsigned P_RESYNC_SLOTS   = 64,
  parameter int unsigned P_RESYNC_TIMEOUT = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_stat_rx_status,
  input  logic [63:0]          i_local_time,
  input  logic                 i_slot_start,
  output logic [SLOT_ID_W-1:0] o_slot_id,
  output logic                 o_slot_boundary,
  output logic                 o_tx_window,
  output logic                 o_resync_req,
  output logic                 o_sync_lost,
  output logic [CNT_W-1:0]     o_jump_cnt
);

  localparam logic [P_SLOT_LEN_LOG2-1:0] GUARD_C  = P_SLOT_LEN_LOG2'(P_GUARD_LEN);
  localparam logic [CNT_W-1:0]           RESYNC_C = CNT_W'(P_RESYNC_SLOTS);
  localparam logic [CNT_W-1:0]           TMO_C    = CNT_W'(P_RESYNC_TIMEOUT);

  logic                       boundary, jump;
  logic [P_SLOT_LEN_LOG2-1:0] offset;

  slot_time_decoder #(.P_SLOT_LEN_LOG2(P_SLOT_LEN_LOG2)) u_dec (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_local_time (i_local_time),
    .o_boundary   (boundary),
    .o_offset     (offset),
    .o_jump       (jump)
  );

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     slot_cnt_q, slot_cnt_d;
  logic [CNT_W-1:0]     tmo_cnt_q, tmo_cnt_d;
  logic [CNT_W-1:0]     jump_cnt_q, jump_cnt_d;
  logic                 pending_q, pending_d;
  logic                 lost_q, lost_d;
  logic                 bnd_q, bnd_d;
  logic                 tx_q, tx_d;
  logic                 req_q, req_d;
  logic [SLOT_ID_W-1:0] slot_id_q, slot_id_d;
  logic                 timeout;

  // A same-cycle i_slot_start wins over the timeout it would otherwise cancel.
  assign timeout = i_stat_rx_status && !i_slot_start && pending_q && boundary &&
                   (state_q != ST_IDLE) && (tmo_cnt_q + 16'd1 == TMO_C);

  always_comb begin
    state_d    = state_q;
    slot_cnt_d = slot_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    jump_cnt_d = jump_cnt_q;
    pending_d  = pending_q;
    lost_d     = lost_q;
    req_d      = 1'b0;

    if (!i_stat_rx_status || timeout) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:       if (i_slot_start) state_d = ST_WAIT_ALIGN;
        ST_WAIT_ALIGN: if (boundary && !jump) state_d = ST_GUARD;
        ST_GUARD: begin
          if (jump)                   state_d = ST_WAIT_ALIGN;
          else if (boundary)          state_d = ST_GUARD;
          else if (offset >= GUARD_C) state_d = ST_ACTIVE;
        end
        default: begin
          if (jump)          state_d = ST_WAIT_ALIGN;
          else if (boundary) state_d = ST_GUARD;
        end
      endcase
    end

    bnd_d = i_stat_rx_status && !timeout && !jump && boundary && (state_q != ST_IDLE);

    if (i_stat_rx_status && !timeout && jump && is_aligned(state_q) && (jump_cnt_q != '1))
      jump_cnt_d = jump_cnt_q + 16'd1;

    if (pending_q && boundary && (state_q != ST_IDLE))
      tmo_cnt_d = tmo_cnt_q + 16'd1;

    if (bnd_d && is_aligned(state_q)) begin
      if (slot_cnt_q + 16'd1 == RESYNC_C) begin
        req_d      = 1'b1;
        slot_cnt_d = '0;
        pending_d  = 1'b1;
        tmo_cnt_d  = '0;
      end else begin
        slot_cnt_d = slot_cnt_q + 16'd1;
      end
    end

    if (timeout) begin
      pending_d = 1'b0;
      tmo_cnt_d = '0;
      lost_d    = 1'b1;
    end

    if (i_slot_start) begin
      pending_d = 1'b0;
      tmo_cnt_d = '0;
      lost_d    = 1'b0;
    end

    if (state_d == ST_IDLE) begin
      slot_cnt_d = '0;
      tmo_cnt_d  = '0;
      pending_d  = 1'b0;
    end

    tx_d      = (state_d == ST_ACTIVE);
    slot_id_d = (state_d == ST_IDLE) ? '0
              : SLOT_ID_W'(i_local_time[P_SLOT_LEN_LOG2 +: P_SLOT_NUM_LOG2]);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      slot_cnt_q <= '0;
      tmo_cnt_q  <= '0;
      jump_cnt_q <= '0;
      pending_q  <= 1'b0;
      lost_q     <= 1'b0;
      bnd_q      <= 1'b0;
      tx_q       <= 1'b0;
      req_q      <= 1'b0;
      slot_id_q  <= '0;
    end else begin
      state_q    <= state_d;
      slot_cnt_q <= slot_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      jump_cnt_q <= jump_cnt_d;
      pending_q  <= pending_d;
      lost_q     <= lost_d;
      bnd_q      <= bnd_d;
      tx_q       <= tx_d;
      req_q      <= req_d;
      slot_id_q  <= slot_id_d;
    end
  end

  assign o_slot_id       = slot_id_q;
  assign o_slot_boundary = bnd_q;
  assign o_tx_window     = tx_q;
  assign o_resync_req    = req_q;
  assign o_sync_lost     = lost_q;
  assign o_jump_cnt      = jump_cnt_q;

endmodule

// File: tb/tb_time_slot_scheduler.sv
// Directed bench for time_slot_scheduler with short re-sync intervals.
module tb_time_slot_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx;
  logic        ss;
  logic [63:0] lt;
  logic [7:0]  slot_id;
  logic        bnd, tx, req, lost;
  logic [15:0] jcnt;

  logic [63:0] cur;
  logic [63:0] nb;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  time_slot_scheduler #(
    .P_RESYNC_SLOTS   (4),
    .P_RESYNC_TIMEOUT (2)
  ) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_stat_rx_status (rx),
    .i_local_time     (lt),
    .i_slot_start     (ss),
    .o_slot_id        (slot_id),
    .o_slot_boundary  (bnd),
    .o_tx_window      (tx),
    .o_resync_req     (req),
    .o_sync_lost      (lost),
    .o_jump_cnt       (jcnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic [63:0] tv, input logic s);
    @(negedge clk);
    lt  = tv;
    ss  = s;
    cur = tv;
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(input logic [63:0] tgt);
    while (cur != tgt) tick(cur + 64'd1, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    rx    = 1'b1;
    ss    = 1'b0;
    lt    = 64'h3EF;
    cur   = 64'h3EF;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_slot_id", slot_id, 0);
    chk("rst_boundary", bnd, 0);
    chk("rst_tx", tx, 0);
    chk("rst_req", req, 0);
    chk("rst_lost", lost, 0);
    chk("rst_jcnt", jcnt, 0);
    rst_n = 1'b1;

    // Alignment
    run_to(64'h3F7);
    tick(64'h3F8, 1'b1);
    chk("start_bnd", bnd, 0);
    chk("start_id", slot_id, 0);
    run_to(64'h3FF);
    chk("pre_align_bnd", bnd, 0);
    tick(64'h400, 1'b0);
    chk("align_bnd", bnd, 1);
    chk("align_id", slot_id, 1);
    chk("align_tx", tx, 0);
    tick(64'h401, 1'b0);
    chk("align_bnd_pulse", bnd, 0);
    run_to(64'h43F);
    chk("guard_tx", tx, 0);
    tick(64'h440, 1'b0);
    chk("active_tx", tx, 1);
    run_to(64'h800);
    chk("b800_bnd", bnd, 1);
    chk("b800_tx", tx, 0);
    chk("b800_id", slot_id, 2);
    run_to(64'h1000);
    chk("b1000_req", req, 0);
    run_to(64'h1400);
    chk("b1400_bnd", bnd, 1);
    chk("b1400_req", req, 1);
    chk("b1400_id", slot_id, 5);
    tick(64'h1401, 1'b0);
    chk("req_pulse", req, 0);

    // Jump in ACTIVE, then re-sync completes
    run_to(64'h1500);
    chk("pre_jump_tx", tx, 1);
    tick(64'h1480, 1'b0);
    chk("jump_tx", tx, 0);
    chk("jump_cnt1", jcnt, 1);
    chk("jump_bnd", bnd, 0);
    run_to(64'h1600);
    tick(64'h1601, 1'b1);
    chk("resync_ok_lost", lost, 0);
    run_to(64'h17FF);
    chk("realign_pre", bnd, 0);
    tick(64'h1800, 1'b0);
    chk("realign_bnd", bnd, 1);
    chk("realign_id", slot_id, 6);
    run_to(64'h1C00);
    chk("resync_ok_bnd", bnd, 1);
    chk("resync_ok_lost2", lost, 0);

    // Re-sync fails
    run_to(64'h2800);
    chk("b2800_req", req, 1);
    run_to(64'h2C00);
    chk("b2C00_lost", lost, 0);
    chk("b2C00_bnd", bnd, 1);
    run_to(64'h3000);
    chk("timeout_lost", lost, 1);
    chk("timeout_tx", tx, 0);
    chk("timeout_id", slot_id, 0);
    run_to(64'h3400);
    chk("idle_bnd", bnd, 0);
    chk("idle_lost_held", lost, 1);

    // i_slot_start on a boundary in IDLE
    run_to(64'h37FF);
    tick(64'h3800, 1'b1);
    chk("ss_on_bnd", bnd, 0);
    chk("ss_clears_lost", lost, 0);
    chk("ss_on_bnd_id", slot_id, 6);
    run_to(64'h3C00);
    chk("b3C00_bnd", bnd, 1);
    chk("b3C00_id", slot_id, 7);
    run_to(64'h4000);
    chk("id_wrap_bnd", bnd, 1);
    chk("id_wrap_id", slot_id, 0);

    // Jump landing on a boundary
    run_to(64'h4100);
    chk("b4100_tx", tx, 1);
    tick(64'h4800, 1'b0);
    chk("jb_bnd", bnd, 0);
    chk("jb_tx", tx, 0);
    chk("jb_cnt", jcnt, 2);
    chk("jb_id", slot_id, 2);
    run_to(64'h4C00);
    chk("jb_realign", bnd, 1);
    run_to(64'h4C50);
    chk("b4C50_tx", tx, 1);

    // Link drop
    rx = 1'b0;
    tick(64'h4C51, 1'b0);
    chk("link_tx", tx, 0);
    chk("link_id", slot_id, 0);
    tick(64'h4C52, 1'b0);
    rx = 1'b1;
    run_to(64'h5000);
    chk("link_bnd_ignored", bnd, 0);
    chk("link_id_hold", slot_id, 0);
    run_to(64'h50FF);
    tick(64'h5100, 1'b1);
    run_to(64'h5400);
    chk("link_realign", bnd, 1);
    chk("link_realign_id", slot_id, 5);

    // 64-bit wrap is not a jump
    tick(64'hFFFF_FFFF_FFFF_FF00, 1'b0);
    chk("wrapjump_cnt", jcnt, 3);
    run_to(64'h0);
    chk("wrap_bnd", bnd, 1);
    chk("wrap_id", slot_id, 0);
    chk("wrap_cnt", jcnt, 3);

    // Saturation
    for (int i = 0; i < 65540; i++) begin
      tick(cur + 64'd1023, 1'b0);
      if (i == 0)     chk("sat_first", jcnt, 4);
      if (i == 65530) chk("sat_fffe", jcnt, 16'hFFFE);
      if (i == 65531) chk("sat_ffff", jcnt, 16'hFFFF);
      tick(cur + 64'd1, 1'b0);
    end
    chk("sat_hold", jcnt, 16'hFFFF);
    chk("sat_bnd", bnd, 1);

    // Reset mid-slot
    run_to(cur + 64'h50);
    chk("prerst_tx", tx, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_tx", tx, 0);
    chk("async_jcnt", jcnt, 0);
    chk("async_id", slot_id, 0);
    nb = (cur | 64'h3FF) + 64'd1;
    run_to(nb - 64'd1);
    rst_n = 1'b1;
    tick(nb, 1'b0);
    chk("release_bnd", bnd, 0);
    chk("release_tx", tx, 0);
    chk("release_id", slot_id, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
